regfile_verify_harness: RTL and testbench

- Synthesizable on-chip successor to the simulation register-check harness.
- Lets the processor run for a programmed number of cycles, then stalls it and takes over regfile read port A.
- Scans every register against an expected-value ROM, then reports pass/fail, the mismatch count, the first failing register and the count of register writes seen during the run.
- Sits between processor and regfile on the rs1 path; drives a synchronous expected-value ROM.

---
 rtl/regfile_verify_harness.sv | 170 +++++++++++++++++
 tb/tb_regfile_verify_harness.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_verify_harness.sv
// rtl/regfile_verify_harness.sv - run/stall/scan harness comparing the regfile against an expected-value ROM
module regfile_verify_harness #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int REG_CNT = 32,
    parameter int CYC_W   = 16,
    parameter int SKIP_R0 = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [CYC_W-1:0]  num_cycles,
    input  logic              rwe,
    input  logic [ADDR_W-1:0] rd,
    input  logic [ADDR_W-1:0] cpu_rs1,
    output logic [ADDR_W-1:0] rf_rs1,
    input  logic [DATA_W-1:0] rf_dataA,
    output logic [ADDR_W-1:0] exp_addr,
    input  logic [DATA_W-1:0] exp_data,
    output logic              cpu_stall,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic              first_fail_valid,
    output logic [ADDR_W-1:0] first_fail_reg,
    output logic [CYC_W-1:0]  write_count
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_SCAN  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // r0 is hard-wired zero on most cores, so it can be left out of the scan
    localparam logic [ADDR_W-1:0] SCAN_FIRST = (SKIP_R0 != 0) ? ADDR_W'(1) : '0;
    localparam logic [ADDR_W-1:0] SCAN_LAST  = ADDR_W'(REG_CNT - 1);

    state_t              state_q, state_d;
    logic [CYC_W-1:0]    len_q, len_d;
    logic [CYC_W-1:0]    cyc_cnt_q, cyc_cnt_d;
    logic [ADDR_W-1:0]   scan_idx_q, scan_idx_d;
    logic [DATA_W-1:0]   act_q, act_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                cmp_v_q, cmp_v_d;
    logic [ADDR_W:0]     err_count_q, err_count_d;
    logic                ff_valid_q, ff_valid_d;
    logic [ADDR_W-1:0]   ff_reg_q, ff_reg_d;
    logic [CYC_W-1:0]    write_count_q, write_count_d;

    // state register and datapath flops
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            len_q         <= '0;
            cyc_cnt_q     <= '0;
            scan_idx_q    <= '0;
            act_q         <= '0;
            idx_q         <= '0;
            cmp_v_q       <= 1'b0;
            err_count_q   <= '0;
            ff_valid_q    <= 1'b0;
            ff_reg_q      <= '0;
            write_count_q <= '0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            cyc_cnt_q     <= cyc_cnt_d;
            scan_idx_q    <= scan_idx_d;
            act_q         <= act_d;
            idx_q         <= idx_d;
            cmp_v_q       <= cmp_v_d;
            err_count_q   <= err_count_d;
            ff_valid_q    <= ff_valid_d;
            ff_reg_q      <= ff_reg_d;
            write_count_q <= write_count_d;
        end
    end

    // next-state logic: run counter, scan issue and the delayed compare stage
    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        cyc_cnt_d     = cyc_cnt_q;
        scan_idx_d    = scan_idx_q;
        act_d         = act_q;
        idx_d         = idx_q;
        cmp_v_d       = 1'b0;
        err_count_d   = err_count_q;
        ff_valid_d    = ff_valid_q;
        ff_reg_d      = ff_reg_q;
        write_count_d = write_count_q;

        // ROM data arrives one cycle after its address, so compare against the captured read
        if (cmp_v_q && (exp_data != act_q)) begin
            if (err_count_q != '1) begin
                err_count_d = err_count_q + 1'b1;
            end
            if (!ff_valid_q) begin
                ff_valid_d = 1'b1;
                ff_reg_d   = idx_q;
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    len_d         = num_cycles;
                    cyc_cnt_d     = '0;
                    err_count_d   = '0;
                    write_count_d = '0;
                    ff_valid_d    = 1'b0;
                    ff_reg_d      = '0;
                    if (num_cycles != '0) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d    = ST_SCAN;
                        scan_idx_d = SCAN_FIRST;
                    end
                end
            end
            ST_RUN: begin
                cyc_cnt_d = cyc_cnt_q + 1'b1;
                if (rwe && (rd != '0) && (write_count_q != '1)) begin
                    write_count_d = write_count_q + 1'b1;
                end
                if (cyc_cnt_q == len_q - 1'b1) begin
                    state_d    = ST_SCAN;
                    scan_idx_d = SCAN_FIRST;
                end
            end
            ST_SCAN: begin
                act_d   = rf_dataA;
                idx_d   = scan_idx_q;
                cmp_v_d = 1'b1;
                // the last index is kept so the read port stays parked on it in DONE
                if (scan_idx_q == SCAN_LAST) begin
                    state_d = ST_DRAIN;
                end else begin
                    scan_idx_d = scan_idx_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // read port A belongs to the processor until the scan takes it over
    always_comb begin
        rf_rs1 = ((state_q == ST_IDLE) || (state_q == ST_RUN)) ? cpu_rs1 : scan_idx_q;
    end

    assign exp_addr         = scan_idx_q;
    assign cpu_stall        = (state_q == ST_SCAN) || (state_q == ST_DRAIN) || (state_q == ST_DONE);
    assign busy             = (state_q == ST_RUN) || (state_q == ST_SCAN) || (state_q == ST_DRAIN);
    assign done             = (state_q == ST_DONE);
    assign pass             = done && (err_count_q == '0);
    assign err_count        = err_count_q;
    assign first_fail_valid = ff_valid_q;
    assign first_fail_reg   = ff_reg_q;
    assign write_count      = write_count_q;

endmodule

// File: tb/tb_regfile_verify_harness.sv
// tb/tb_regfile_verify_harness.sv - directed vector bench for regfile_verify_harness
module tb_regfile_verify_harness;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] num_cycles;
    logic        rwe;
    logic [4:0]  rd;
    logic [4:0]  cpu_rs1;

    // instance 1 skips r0, instance 0 scans r0 too
    logic [4:0]  rf_rs1_1, exp_addr_1, ffr_1;
    logic [31:0] rf_data_1, exp_data_1;
    logic        stall_1, busy_1, done_1, pass_1, ffv_1;
    logic [5:0]  err_1;
    logic [15:0] wc_1;

    logic [4:0]  rf_rs1_0, exp_addr_0, ffr_0;
    logic [31:0] rf_data_0, exp_data_0;
    logic        stall_0, busy_0, done_0, pass_0, ffv_0;
    logic [5:0]  err_0;
    logic [15:0] wc_0;

    logic [31:0] rf_mem [32];
    logic [31:0] rom    [32];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    assign rf_data_1 = rf_mem[rf_rs1_1];
    assign rf_data_0 = rf_mem[rf_rs1_0];

    // synchronous expected-value ROM, one read port per instance
    always @(posedge clock) begin
        exp_data_1 <= rom[exp_addr_1];
        exp_data_0 <= rom[exp_addr_0];
    end

    regfile_verify_harness #(.SKIP_R0(1)) dut1 (
        .clock(clock), .reset(reset), .start(start), .num_cycles(num_cycles),
        .rwe(rwe), .rd(rd), .cpu_rs1(cpu_rs1), .rf_rs1(rf_rs1_1), .rf_dataA(rf_data_1),
        .exp_addr(exp_addr_1), .exp_data(exp_data_1), .cpu_stall(stall_1), .busy(busy_1),
        .done(done_1), .pass(pass_1), .err_count(err_1), .first_fail_valid(ffv_1),
        .first_fail_reg(ffr_1), .write_count(wc_1)
    );

    regfile_verify_harness #(.SKIP_R0(0)) dut0 (
        .clock(clock), .reset(reset), .start(start), .num_cycles(num_cycles),
        .rwe(rwe), .rd(rd), .cpu_rs1(cpu_rs1), .rf_rs1(rf_rs1_0), .rf_dataA(rf_data_0),
        .exp_addr(exp_addr_0), .exp_data(exp_data_0), .cpu_stall(stall_0), .busy(busy_0),
        .done(done_0), .pass(pass_0), .err_count(err_0), .first_fail_valid(ffv_0),
        .first_fail_reg(ffr_0), .write_count(wc_0)
    );

    typedef struct {
        int          len;
        logic [31:0] bad_mask;
        int          err1;
        logic        ffv1;
        int          ffr1;
        logic        pass1;
        int          err0;
        int          ffr0;
        logic        pass0;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_rom(input logic [31:0] mask);
        for (int i = 0; i < 32; i++) begin
            rom[i] = rf_mem[i] ^ (mask[i] ? 32'h0000_0100 : 32'h0);
        end
    endtask

    // wait for both instances to finish; returns edges counted from the start edge
    task automatic wait_done(input int k0, output int lat1, output int lat0, output int busy_n);
        int k;
        k      = k0;
        lat1   = -1;
        lat0   = -1;
        busy_n = 0;
        while (k < 300 && (lat1 < 0 || lat0 < 0)) begin
            @(posedge clock);
            #1;
            k++;
            if (busy_1) busy_n++;
            if (done_1 && lat1 < 0) lat1 = k;
            if (done_0 && lat0 < 0) lat0 = k;
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int lat1, lat0, busy_n;
        string t;
        t = $sformatf("v%0d", id);
        load_rom(v.bad_mask);
        @(negedge clock);
        num_cycles = 16'(v.len);
        start      = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_done(0, lat1, lat0, busy_n);
        if (busy_1) busy_n++;
        check({t, " latency1"}, 32'(lat1), 32'(v.len + 32));
        check({t, " latency0"}, 32'(lat0), 32'(v.len + 33));
        check({t, " busy_cycles"}, 32'(busy_n + 1), 32'(v.len + 32));
        check({t, " err1"}, 32'(err_1), 32'(v.err1));
        check({t, " ffv1"}, 32'(ffv_1), 32'(v.ffv1));
        check({t, " ffr1"}, 32'(ffr_1), 32'(v.ffr1));
        check({t, " pass1"}, 32'(pass_1), 32'(v.pass1));
        check({t, " err0"}, 32'(err_0), 32'(v.err0));
        check({t, " ffr0"}, 32'(ffr_0), 32'(v.ffr0));
        check({t, " pass0"}, 32'(pass_0), 32'(v.pass0));
        check({t, " wc1"}, 32'(wc_1), 32'h0);
        check({t, " rf_rs1_done"}, 32'(rf_rs1_1), 32'd31);
    endtask

    initial begin
        int lat1, lat0, busy_n, k;
        logic       rwe_seq [10];
        logic [4:0] rd_seq  [10];

        vecs[0] = '{len: 5, bad_mask: 32'h0000_0000, err1: 0, ffv1: 1'b0, ffr1: 0,
                    pass1: 1'b1, err0: 0, ffr0: 0, pass0: 1'b1};
        vecs[1] = '{len: 5, bad_mask: 32'h0002_0008, err1: 2, ffv1: 1'b1, ffr1: 3,
                    pass1: 1'b0, err0: 2, ffr0: 3, pass0: 1'b0};
        vecs[2] = '{len: 0, bad_mask: 32'h0000_0001, err1: 0, ffv1: 1'b0, ffr1: 0,
                    pass1: 1'b1, err0: 1, ffr0: 0, pass0: 1'b0};
        vecs[3] = '{len: 3, bad_mask: 32'h8000_0001, err1: 1, ffv1: 1'b1, ffr1: 31,
                    pass1: 1'b0, err0: 2, ffr0: 0, pass0: 1'b0};
        vecs[4] = '{len: 1, bad_mask: 32'h4000_0002, err1: 2, ffv1: 1'b1, ffr1: 1,
                    pass1: 1'b0, err0: 2, ffr0: 1, pass0: 1'b0};

        rwe_seq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        rd_seq  = '{5'd0, 5'd4, 5'd9, 5'd0, 5'd4, 5'd4, 5'd9, 5'd9, 5'd7, 5'd7};

        for (int i = 0; i < 32; i++) begin
            rf_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
        end
        load_rom(32'h0);

        reset      = 1'b1;
        start      = 1'b0;
        num_cycles = 16'd0;
        rwe        = 1'b0;
        rd         = 5'd0;
        cpu_rs1    = 5'd6;
        repeat (3) @(posedge clock);
        #1;
        check("rst busy", 32'(busy_1), 32'h0);
        check("rst done", 32'(done_1), 32'h0);
        check("rst stall", 32'(stall_1), 32'h0);
        check("rst err", 32'(err_1), 32'h0);
        check("rst rf_rs1", 32'(rf_rs1_1), 32'd6);
        check("rst exp_addr", 32'(exp_addr_1), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("idle pass", 32'(pass_1), 32'h0);
        check("idle ffv", 32'(ffv_1), 32'h0);

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], i);
        end

        // write counting: rd=0 ignored, start during RUN ignored, writes in SCAN ignored
        load_rom(32'h0);
        @(negedge clock);
        num_cycles = 16'd8;
        start      = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rwe   = rwe_seq[i];
            rd    = rd_seq[i];
            start = (i == 3);
            @(posedge clock);
            #1;
        end
        rwe   = 1'b0;
        start = 1'b0;
        wait_done(10, lat1, lat0, busy_n);
        check("wc count", 32'(wc_1), 32'd3);
        check("wc latency", 32'(lat1), 32'd40);
        check("wc pass", 32'(pass_1), 32'h1);

        // zero-length run enters SCAN right after the start edge
        @(negedge clock);
        num_cycles = 16'd0;
        start      = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        check("len0 stall", 32'(stall_1), 32'h1);
        check("len0 busy", 32'(busy_1), 32'h1);
        check("len0 rf_rs1", 32'(rf_rs1_1), 32'd1);
        check("len0 rf_rs1 r0", 32'(rf_rs1_0), 32'd0);
        wait_done(0, lat1, lat0, busy_n);
        check("len0 latency", 32'(lat1), 32'd32);

        // reset in the middle of a scan
        load_rom(32'h0000_0008);
        cpu_rs1 = 5'd5;
        @(negedge clock);
        num_cycles = 16'd2;
        start      = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        k = 0;
        while (k < 60 && !(stall_1 && rf_rs1_1 == 5'd10)) begin
            @(posedge clock);
            #1;
            k++;
        end
        check("mid idx10 edge", 32'(k), 32'd11);
        check("mid err before", 32'(err_1), 32'd1);
        reset = 1'b1;
        #1;
        check("mid rst busy", 32'(busy_1), 32'h0);
        check("mid rst done", 32'(done_1), 32'h0);
        check("mid rst err", 32'(err_1), 32'h0);
        check("mid rst ffv", 32'(ffv_1), 32'h0);
        check("mid rst stall", 32'(stall_1), 32'h0);
        check("mid rst rf_rs1", 32'(rf_rs1_1), 32'd5);
        @(negedge clock);
        reset = 1'b0;
        run_vec(vecs[0], 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
